// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two valid/ready requesters.
// Optional grant statistics are enabled by defining ALU_ARB_STATS_EN.

module alu_arbiter_alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Combinational ALU; unused control codes yield zero
  always_comb begin
    result = {WIDTH{1'b0}};
    case (alu_control)
      3'b000:  result = a + b;
      3'b001:  result = a - b;
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b101:  result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = {WIDTH{1'b0}};
    endcase
  end

  assign zero = (result == {WIDTH{1'b0}});

endmodule

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ReqValid0,
  output logic             ReqReady0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [2:0]       Ctrl0,
  input  logic             ReqValid1,
  output logic             ReqReady1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic [2:0]       Ctrl1,
  output logic             RespValid,
  input  logic             RespReady,
  output logic [WIDTH-1:0] RespResult,
  output logic             RespZero,
  output logic             RespId,
  output logic [CNT_W-1:0] GrantCnt0,
  output logic [CNT_W-1:0] GrantCnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             grant0_s;
  logic             grant1_s;
  logic             last_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [2:0]       op_ctrl_r;
  logic             op_id_r;
  logic [WIDTH-1:0] alu_result_s;
  logic             alu_zero_s;

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .a           (op_a_r),
    .b           (op_b_r),
    .alu_control (op_ctrl_r),
    .result      (alu_result_s),
    .zero        (alu_zero_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state and grant selection; on contention the requester not granted last wins
  always_comb begin
    state_next_s = state_r;
    grant0_s     = 1'b0;
    grant1_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (ReqValid0 && ReqValid1) begin
          grant0_s = last_r;
          grant1_s = ~last_r;
        end else begin
          grant0_s = ReqValid0;
          grant1_s = ReqValid1;
        end
        if (ReqValid0 || ReqValid1) state_next_s = EXEC;
        else                        state_next_s = IDLE;
      end
      EXEC: state_next_s = RESP;
      RESP: begin
        if (RespReady) state_next_s = IDLE;
        else           state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  assign ReqReady0 = grant0_s;
  assign ReqReady1 = grant1_s;

  // Operand capture, round-robin pointer and response slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_r     <= {WIDTH{1'b0}};
      op_b_r     <= {WIDTH{1'b0}};
      op_ctrl_r  <= 3'b000;
      op_id_r    <= 1'b0;
      last_r     <= 1'b1;
      RespValid  <= 1'b0;
      RespResult <= {WIDTH{1'b0}};
      RespZero   <= 1'b0;
      RespId     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            op_a_r    <= grant1_s ? A1 : A0;
            op_b_r    <= grant1_s ? B1 : B0;
            op_ctrl_r <= grant1_s ? Ctrl1 : Ctrl0;
            op_id_r   <= grant1_s;
            last_r    <= grant1_s;
          end
        end
        EXEC: begin
          RespResult <= alu_result_s;
          RespZero   <= alu_zero_s;
          RespId     <= op_id_r;
          RespValid  <= 1'b1;
        end
        RESP: begin
          if (RespReady) RespValid <= 1'b0;
        end
        default: RespValid <= 1'b0;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  // Saturating per-requester grant counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else begin
      if (grant0_s && (cnt0_r != {CNT_W{1'b1}})) cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (grant1_s && (cnt1_r != {CNT_W{1'b1}})) cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign GrantCnt0 = cnt0_r;
  assign GrantCnt1 = cnt1_r;
`else
  assign GrantCnt0 = {CNT_W{1'b0}};
  assign GrantCnt1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: single ops, round-robin, back-pressure,
// ALU corner cases, mid-operation reset and grant counters.

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ReqValid0 = 1'b0, ReqValid1 = 1'b0;
  logic        ReqReady0, ReqReady1;
  logic [31:0] A0 = 32'd0, B0 = 32'd0, A1 = 32'd0, B1 = 32'd0;
  logic [2:0]  Ctrl0 = 3'd0, Ctrl1 = 3'd0;
  logic        RespValid, RespZero, RespId;
  logic        RespReady = 1'b0;
  logic [31:0] RespResult;
  logic [15:0] GrantCnt0, GrantCnt1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ReqValid0(ReqValid0), .ReqReady0(ReqReady0), .A0(A0), .B0(B0), .Ctrl0(Ctrl0),
    .ReqValid1(ReqValid1), .ReqReady1(ReqReady1), .A1(A1), .B1(B1), .Ctrl1(Ctrl1),
    .RespValid(RespValid), .RespReady(RespReady), .RespResult(RespResult),
    .RespZero(RespZero), .RespId(RespId), .GrantCnt0(GrantCnt0), .GrantCnt1(GrantCnt1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic single_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] ctrl, input logic [31:0] exp_res,
                           input logic exp_zero, input string tag);
    int n;
    if (id) begin A1 = a; B1 = b; Ctrl1 = ctrl; ReqValid1 = 1'b1; end
    else    begin A0 = a; B0 = b; Ctrl0 = ctrl; ReqValid0 = 1'b1; end
    #1;
    n = 0;
    while (((id ? ReqReady1 : ReqReady0) !== 1'b1) && n < 8) begin
      step();
      n++;
    end
    check_eq({tag, "_ready"}, {31'd0, (id ? ReqReady1 : ReqReady0)}, 32'd1);
    step();
    ReqValid0 = 1'b0;
    ReqValid1 = 1'b0;
    #1;
    check_eq({tag, "_exec_rv"}, {31'd0, RespValid}, 32'd0);
    step();
    check_eq({tag, "_rv"}, {31'd0, RespValid}, 32'd1);
    check_eq({tag, "_res"}, RespResult, exp_res);
    check_eq({tag, "_zero"}, {31'd0, RespZero}, {31'd0, exp_zero});
    check_eq({tag, "_id"}, {31'd0, RespId}, {31'd0, id});
    RespReady = 1'b1;
    step();
    RespReady = 1'b0;
    #1;
    check_eq({tag, "_rv_clr"}, {31'd0, RespValid}, 32'd0);
  endtask

  initial begin
    do_reset();
    check_eq("rst_rv", {31'd0, RespValid}, 32'd0);
    check_eq("rst_res", RespResult, 32'd0);
    check_eq("rst_zero", {31'd0, RespZero}, 32'd0);
    check_eq("rst_id", {31'd0, RespId}, 32'd0);
    check_eq("rst_cnt0", {16'd0, GrantCnt0}, 32'd0);

    // Both requesters valid from reset: grants alternate 0,1,0,1
    A0 = 32'd7;    B0 = 32'd7;    Ctrl0 = 3'b001; ReqValid0 = 1'b1;
    A1 = 32'hF0;   B1 = 32'h0F;   Ctrl1 = 3'b011; ReqValid1 = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rr%0d_rdy0", k), {31'd0, ReqReady0}, {31'd0, (k % 2 == 0)});
      check_eq($sformatf("rr%0d_rdy1", k), {31'd0, ReqReady1}, {31'd0, (k % 2 == 1)});
      step();
      check_eq($sformatf("rr%0d_exec_rdy", k), {30'd0, ReqReady1, ReqReady0}, 32'd0);
      check_eq($sformatf("rr%0d_exec_rv", k), {31'd0, RespValid}, 32'd0);
      step();
      check_eq($sformatf("rr%0d_rv", k), {31'd0, RespValid}, 32'd1);
      check_eq($sformatf("rr%0d_res", k), RespResult, (k % 2 == 0) ? 32'd0 : 32'hFF);
      check_eq($sformatf("rr%0d_zero", k), {31'd0, RespZero}, {31'd0, (k % 2 == 0)});
      check_eq($sformatf("rr%0d_id", k), {31'd0, RespId}, {31'd0, (k % 2 == 1)});
      if (k == 0) begin
        for (int h = 0; h < 5; h++) begin
          step();
          check_eq($sformatf("hold%0d_rv", h), {31'd0, RespValid}, 32'd1);
          check_eq($sformatf("hold%0d_res", h), RespResult, 32'd0);
          check_eq($sformatf("hold%0d_zero", h), {31'd0, RespZero}, 32'd1);
          check_eq($sformatf("hold%0d_id", h), {31'd0, RespId}, 32'd0);
          check_eq($sformatf("hold%0d_rdy", h), {30'd0, ReqReady1, ReqReady0}, 32'd0);
        end
      end
      RespReady = 1'b1;
      #1;
      check_eq($sformatf("rr%0d_resp_rdy", k), {30'd0, ReqReady1, ReqReady0}, 32'd0);
      step();
      RespReady = 1'b0;
      #1;
      check_eq($sformatf("rr%0d_rv_clr", k), {31'd0, RespValid}, 32'd0);
    end
    ReqValid0 = 1'b0;
    ReqValid1 = 1'b0;
    #1;

    single_op(1'b0, 32'd5, 32'd3, 3'b000, 32'd8, 1'b0, "add5_3");

`ifdef ALU_ARB_STATS_EN
    check_eq("cnt0", {16'd0, GrantCnt0}, 32'd3);
    check_eq("cnt1", {16'd0, GrantCnt1}, 32'd2);
`else
    check_eq("cnt0", {16'd0, GrantCnt0}, 32'd0);
    check_eq("cnt1", {16'd0, GrantCnt1}, 32'd0);
`endif

    single_op(1'b1, 32'd1, 32'hFFFFFFFF, 3'b101, 32'd1, 1'b0, "slt_u");
    single_op(1'b1, 32'hFFFFFFFF, 32'd1, 3'b101, 32'd0, 1'b1, "slt_u_rev");
    single_op(1'b1, 32'd1, 32'hFFFFFFFF, 3'b111, 32'd0, 1'b1, "ctrl111");
    single_op(1'b0, 32'hFFFFFFFF, 32'd1, 3'b000, 32'd0, 1'b1, "add_wrap");
    single_op(1'b0, 32'd0, 32'd1, 3'b001, 32'hFFFFFFFF, 1'b0, "sub_wrap");
    single_op(1'b1, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 3'b010, 32'h05A0_0F0F, 1'b0, "and");

    // Reset while an operation is in EXEC
    A0 = 32'd1; B0 = 32'd1; Ctrl0 = 3'b000; ReqValid0 = 1'b1;
    #1;
    check_eq("mid_rdy0", {31'd0, ReqReady0}, 32'd1);
    step();
    ReqValid0 = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_rv", {31'd0, RespValid}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("post_rst%0d_rv", c), {31'd0, RespValid}, 32'd0);
      step();
    end
    A0 = 32'd2;  B0 = 32'd2;  Ctrl0 = 3'b000; ReqValid0 = 1'b1;
    A1 = 32'd9;  B1 = 32'd9;  Ctrl1 = 3'b000; ReqValid1 = 1'b1;
    #1;
    check_eq("post_rst_rdy0", {31'd0, ReqReady0}, 32'd1);
    check_eq("post_rst_rdy1", {31'd0, ReqReady1}, 32'd0);
    step();
    ReqValid0 = 1'b0;
    ReqValid1 = 1'b0;
    step();
    check_eq("post_rst_res", RespResult, 32'd4);
    check_eq("post_rst_id", {31'd0, RespId}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
